rx_lmfc_tracker: RTL and testbench
==================================

// Module: rx_lmfc_tracker
// PURPOSE
//  Receive-side multiframe tracker for the JESD204B link. Counts received frames (one frame per clk,
//  frame clock == device clock), locks onto /A/ (K28.3) end-of-multiframe markers and measures their
//  offset against the local LMFC pulse. Asserts an elastic-buffer release at the programmed RX buffer
//  delay (RBD) and drops lock on repeated misaligned /A/. Sits between the 8b/10b lane decoder and the lane elastic buffer.
// PARAMETERS
//  LOCK_CNT    2  consecutive correctly spaced /A/ (after first) required to reach LOCKED; range 1..7
//  UNLOCK_CNT  2  consecutive misplaced /A/ in LOCKED that force realignment; range 1..7
// PORTS
//  clk           in   1  device clock; all logic on posedge
//  rst_n         in   1  asynchronous active-low reset
//  i_K           in   5  frames per multiframe minus 1 (binary value - 1, 1..32 frames); static while locked
//  i_rbd         in   5  release point in local LMFC phase, 0..i_K
//  i_lmfc_clk    in   1  local LMFC pulse, high for 1 clk per multiframe
//  i_data_valid  in   1  decoded lane data valid (CGS done); low = link lost
//  i_is_a        in   1  current frame's last octet is /A/; ignored when i_data_valid=0
//  o_mf_start    out  1  pulse: current rx frame is first of a multiframe (LOCKED only)
//  o_rx_frame    out  5  rx frame index within multiframe, 0..i_K
//  o_lmfc_offset out  5  local LMFC phase sampled at the /A/ that started lock
//  o_aligned     out  1  high in LOCKED
//  o_release     out  1  elastic-buffer read release; sticky while LOCKED
//  o_align_err   out  1  1-clk pulse on LOCKED->SEARCH due to misalignment
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state SEARCH, all counters 0.
//  Local phase loc_cnt: 0 in cycle i_lmfc_clk=1; else wraps i_K->0, otherwise +1. Width 5, no overflow.
//  rx_cnt: after an accepted /A/ it is 0 next cycle; then +1 per clk, wrap i_K->0. Output o_rx_frame = rx_cnt.
//  States:
//   SEARCH: first /A/ -> rx_cnt<=0, o_lmfc_offset<=loc_cnt, ok_cnt<=0, go CHECK.
//   CHECK: /A/ with rx_cnt==i_K -> ok_cnt+1; reaching LOCK_CNT -> LOCKED (o_aligned=1 next clk).
//          /A/ with rx_cnt!=i_K -> resync: treat as new first /A/ (offset resampled), stay CHECK, ok_cnt<=0.
//   LOCKED: /A/ at rx_cnt==i_K -> mis_cnt<=0. /A/ elsewhere -> mis_cnt+1, rx_cnt NOT adjusted.
//           mis_cnt reaching UNLOCK_CNT -> SEARCH, o_align_err=1 for 1 clk, o_aligned/o_release <=0.
//           Multiframes without /A/ (scrambled data) are neither ok nor miss.
//  o_mf_start = LOCKED && rx_cnt==0 (combinational from registers, no extra latency).
//  o_release: in LOCKED, set in first clk where loc_cnt==i_rbd; stays 1 until leaving LOCKED.
//  i_data_valid=0 in any state: next clk SEARCH, all outputs 0 except o_lmfc_offset (held); no o_align_err.
//  Simultaneous i_lmfc_clk and /A/: offset samples loc_cnt=0.
//  i_K change while not in SEARCH: undefined; bench must drop i_data_valid first.
//  i_rbd > i_K: o_release never asserts (no error flagged).
// CONFIGURATION
//  RX_LMFC_STATS_EN defined: adds port o_realign_cnt out 8 = saturating (holds at 255) count of
//   misalignment-induced LOCKED->SEARCH transitions; reset to 0 only by rst_n.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 K=3 (4 frames), /A/ every 4 clk, LOCK_CNT=2 -> o_aligned=1 one clk after 3rd /A/; o_mf_start every 4 clk.
//  2 K=3, lmfc pulse 2 clk before first /A/ -> o_lmfc_offset=2; i_rbd=1 -> o_release rises at next loc_cnt==1 after lock.
//  3 Locked K=31, two consecutive /A/ at rx_cnt=5 -> o_align_err pulse, o_aligned=0, state SEARCH.
//  4 Locked, one misplaced /A/ then correct /A/ -> stays LOCKED, mis_cnt cleared, no o_align_err.
//  5 i_data_valid=0 mid-LOCKED and rst_n low mid-CHECK -> outputs 0 next clk/immediately; relock from scratch.
//  6 RX_LMFC_STATS_EN: 257 forced realignments -> o_realign_cnt=255; without macro bench compiles without port.

Source files
------------

// File: rtl/rx_lmfc_tracker.sv
// JESD204B receive multiframe tracker: locks to /A/ markers, measures offset to the local LMFC, releases the elastic buffer.
// Optional saturating realignment counter (o_realign_cnt) is enabled by defining RX_LMFC_STATS_EN.
module rx_lmfc_tracker #(
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_K,
    input  logic [4:0] i_rbd,
    input  logic       i_lmfc_clk,
    input  logic       i_data_valid,
    input  logic       i_is_a,
    output logic       o_mf_start,
    output logic [4:0] o_rx_frame,
    output logic [4:0] o_lmfc_offset,
    output logic       o_aligned,
    output logic       o_release,
`ifdef RX_LMFC_STATS_EN
    output logic [7:0] o_realign_cnt,
`endif
    output logic       o_align_err
);

    typedef enum logic [1:0] {
        SEARCH,
        CHECK,
        LOCKED
    } state_t;

    localparam logic [2:0] LOCK_N   = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_N = 3'(UNLOCK_CNT);

    state_t     state;
    logic [4:0] loc_reg;
    logic [4:0] loc_cnt;
    logic [4:0] rx_cnt;
    logic [4:0] rx_next;
    logic       rx_at_end;
    logic [2:0] ok_cnt;
    logic [2:0] mis_cnt;

    // The LMFC pulse forces phase 0 in its own cycle, so an /A/ coincident with it samples 0.
    assign loc_cnt   = i_lmfc_clk ? 5'd0 : loc_reg;
    assign rx_at_end = (rx_cnt == i_K);
    assign rx_next   = rx_at_end ? 5'd0 : rx_cnt + 5'd1;

    assign o_rx_frame = rx_cnt;
    assign o_mf_start = (state == LOCKED) && (rx_cnt == 5'd0);

    // NOTE: every register below is updated with <= so all reads within a clock see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loc_reg <= 5'd0;
        end else begin
            loc_reg <= (loc_cnt == i_K) ? 5'd0 : loc_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            rx_cnt        <= 5'd0;
            ok_cnt        <= 3'd0;
            mis_cnt       <= 3'd0;
            o_lmfc_offset <= 5'd0;
            o_aligned     <= 1'b0;
            o_release     <= 1'b0;
            o_align_err   <= 1'b0;
`ifdef RX_LMFC_STATS_EN
            o_realign_cnt <= 8'd0;
`endif
        end else begin
            o_align_err <= 1'b0;
            if (!i_data_valid) begin
                // Link lost: drop everything except the last measured offset.
                state     <= SEARCH;
                rx_cnt    <= 5'd0;
                ok_cnt    <= 3'd0;
                mis_cnt   <= 3'd0;
                o_aligned <= 1'b0;
                o_release <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (i_is_a) begin
                            rx_cnt        <= 5'd0;
                            o_lmfc_offset <= loc_cnt;
                            ok_cnt        <= 3'd0;
                            state         <= CHECK;
                        end
                    end
                    CHECK: begin
                        rx_cnt <= rx_next;
                        if (i_is_a) begin
                            if (rx_at_end) begin
                                if (ok_cnt + 3'd1 == LOCK_N) begin
                                    state     <= LOCKED;
                                    o_aligned <= 1'b1;
                                    mis_cnt   <= 3'd0;
                                end else begin
                                    ok_cnt <= ok_cnt + 3'd1;
                                end
                            end else begin
                                rx_cnt        <= 5'd0;
                                o_lmfc_offset <= loc_cnt;
                                ok_cnt        <= 3'd0;
                            end
                        end
                    end
                    LOCKED: begin
                        rx_cnt <= rx_next;
                        if (loc_cnt == i_rbd) begin
                            o_release <= 1'b1;
                        end
                        // Misplaced /A/ are counted but never move the frame counter.
                        if (i_is_a) begin
                            if (rx_at_end) begin
                                mis_cnt <= 3'd0;
                            end else if (mis_cnt + 3'd1 == UNLOCK_N) begin
                                state       <= SEARCH;
                                rx_cnt      <= 5'd0;
                                ok_cnt      <= 3'd0;
                                mis_cnt     <= 3'd0;
                                o_aligned   <= 1'b0;
                                o_release   <= 1'b0;
                                o_align_err <= 1'b1;
`ifdef RX_LMFC_STATS_EN
                                if (o_realign_cnt != 8'hFF) begin
                                    o_realign_cnt <= o_realign_cnt + 8'd1;
                                end
`endif
                            end else begin
                                mis_cnt <= mis_cnt + 3'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_lmfc_tracker.sv
// Self-checking bench for rx_lmfc_tracker: phase-anchor model compared every cycle plus literal spot checks.
// Define RX_LMFC_STATS_EN to also exercise o_realign_cnt saturation.
module tb_rx_lmfc_tracker;

    localparam int LOCK_CNT   = 2;
    localparam int UNLOCK_CNT = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] k     = 5'd3;
    logic [4:0] rbd   = 5'd1;
    logic       lmfc  = 1'b0;
    logic       valid = 1'b0;
    logic       is_a  = 1'b0;

    logic       o_mf_start;
    logic [4:0] o_rx_frame;
    logic [4:0] o_lmfc_offset;
    logic       o_aligned;
    logic       o_release;
    logic       o_align_err;
`ifdef RX_LMFC_STATS_EN
    logic [7:0] o_realign_cnt;
`endif

    rx_lmfc_tracker #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_K          (k),
        .i_rbd        (rbd),
        .i_lmfc_clk   (lmfc),
        .i_data_valid (valid),
        .i_is_a       (is_a),
        .o_mf_start   (o_mf_start),
        .o_rx_frame   (o_rx_frame),
        .o_lmfc_offset(o_lmfc_offset),
        .o_aligned    (o_aligned),
        .o_release    (o_release),
`ifdef RX_LMFC_STATS_EN
        .o_realign_cnt(o_realign_cnt),
`endif
        .o_align_err  (o_align_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phases are derived from anchor cycles with modular arithmetic.
    int         m_mode;      // 0 search, 1 check, 2 locked
    int         rx_anchor;   // cycle in which the rx frame index is 0
    int         loc_anchor;  // cycle in which the local phase is 0
    int         good;
    int         miss;
    logic [4:0] m_off;
    logic       m_al;
    logic       m_rel;
    logic       m_err;
    int         m_stats;

    function automatic int ph(input int n, input int anchor, input int kk);
        int p;
        p = kk + 1;
        return (((n - anchor) % p) + p) % p;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        int rx;
        int lp;
        m_stats = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_mode = 0; good = 0; miss = 0; m_off = 5'd0;
                m_al = 1'b0; m_rel = 1'b0; m_err = 1'b0; m_stats = 0;
                rx_anchor = 0;
                loc_anchor = cyc + 1;
            end
            rx = (m_mode == 0) ? 0 : ph(cyc, rx_anchor, int'(k));
            check("rx_frame", 32'(o_rx_frame), 32'(rx));
            check("mf_start", 32'(o_mf_start), 32'(m_mode == 2 && rx == 0));
            check("aligned", 32'(o_aligned), 32'(m_al));
            check("release", 32'(o_release), 32'(m_rel));
            check("align_err", 32'(o_align_err), 32'(m_err));
            check("lmfc_offset", 32'(o_lmfc_offset), 32'(m_off));
`ifdef RX_LMFC_STATS_EN
            check("realign_cnt", 32'(o_realign_cnt), 32'(m_stats));
`endif
            if (rst_n) begin
                m_err = 1'b0;
                if (lmfc) loc_anchor = cyc;
                lp = ph(cyc, loc_anchor, int'(k));
                rx = ph(cyc, rx_anchor, int'(k));
                if (m_mode == 2 && lp == int'(rbd)) m_rel = 1'b1;
                if (!valid) begin
                    m_mode = 0; m_al = 1'b0; m_rel = 1'b0; good = 0; miss = 0;
                end else if (is_a) begin
                    if (m_mode == 0) begin
                        rx_anchor = cyc + 1; m_off = 5'(lp); good = 0; m_mode = 1;
                    end else if (m_mode == 1) begin
                        if (rx == int'(k)) begin
                            good = good + 1;
                            if (good == LOCK_CNT) begin
                                m_mode = 2; m_al = 1'b1; miss = 0;
                            end
                        end else begin
                            rx_anchor = cyc + 1; m_off = 5'(lp); good = 0;
                        end
                    end else begin
                        if (rx == int'(k)) begin
                            miss = 0;
                        end else begin
                            miss = miss + 1;
                            if (miss == UNLOCK_CNT) begin
                                m_mode = 0; m_al = 1'b0; m_rel = 1'b0; m_err = 1'b1;
                                good = 0; miss = 0;
                                if (m_stats < 255) m_stats = m_stats + 1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic a, input logic l);
        @(posedge clk);
        #1;
        valid = v;
        is_a  = a;
        lmfc  = l;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_aligned", 32'(o_aligned), 32'd0);
        check("reset_rx_frame", 32'(o_rx_frame), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // K=3, LMFC two frames before first /A/, /A/ every 4 frames, release at phase 1.
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'(i % 4 == 2), 1'(i % 4 == 0));
            @(negedge clk);
            if (i == 10) check("t1_not_yet_aligned", 32'(o_aligned), 32'd0);
            if (i == 11) begin
                check("t1_aligned", 32'(o_aligned), 32'd1);
                check("t2_offset", 32'(o_lmfc_offset), 32'd2);
                check("t1_mf_start", 32'(o_mf_start), 32'd1);
            end
            if (i == 12) check("t1_mf_start_low", 32'(o_mf_start), 32'd0);
            if (i == 13) check("t2_release_low", 32'(o_release), 32'd0);
            if (i == 14) check("t2_release_high", 32'(o_release), 32'd1);
        end

        // One misplaced /A/ followed by a correct one, twice: lock must hold.
        for (int j = 0; j < 16; j++) begin
            drive(1'b1, 1'(j % 4 == 2 || j == 1 || j == 9), 1'(j % 4 == 0));
            @(negedge clk);
            if (j == 15) begin
                check("t4_still_aligned", 32'(o_aligned), 32'd1);
                check("t4_release", 32'(o_release), 32'd1);
            end
        end

        // Link lost while locked, then switch to K=31 with a fresh LMFC pulse.
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        k = 5'd31;
        @(negedge clk);
        check("t5_valid_drop_aligned", 32'(o_aligned), 32'd0);
        check("t5_valid_drop_release", 32'(o_release), 32'd0);
        check("t5_valid_drop_offset", 32'(o_lmfc_offset), 32'd2);

        // K=31: lock, then two misplaced /A/ at rx frame 5.
        for (int i = 0; i < 160; i++) begin
            drive(1'b1, 1'((i % 32 == 10 && i <= 106) || i == 112 || i == 144), 1'(i % 32 == 0));
            @(negedge clk);
            if (i == 75)  check("t3_aligned", 32'(o_aligned), 32'd1);
            if (i == 112) check("t3_rx_at_miss", 32'(o_rx_frame), 32'd5);
            if (i == 144) check("t3_aligned_after_1miss", 32'(o_aligned), 32'd1);
            if (i == 145) begin
                check("t3_align_err", 32'(o_align_err), 32'd1);
                check("t3_unaligned", 32'(o_aligned), 32'd0);
            end
            if (i == 146) check("t3_align_err_pulse", 32'(o_align_err), 32'd0);
        end

        // Enter CHECK, then asynchronous reset mid-cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'(i == 3), 1'b0);
            @(negedge clk);
            if (i == 7) begin
                check("t5_check_offset", 32'(o_lmfc_offset), 32'd3);
                check("t5_check_rx", 32'(o_rx_frame), 32'd3);
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async_rx", 32'(o_rx_frame), 32'd0);
        check("t5_async_offset", 32'(o_lmfc_offset), 32'd0);
        k   = 5'd3;
        rbd = 5'd5;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Relock: coincident LMFC and /A/, a resync in CHECK, release point beyond K.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'(i == 0 || i == 3 || (i % 4 == 3 && i >= 7)), 1'(i % 4 == 0));
            @(negedge clk);
            if (i == 1)  check("t5_offset_coincident", 32'(o_lmfc_offset), 32'd0);
            if (i == 4)  check("t5_offset_resync", 32'(o_lmfc_offset), 32'd3);
            if (i == 11) check("t5_not_yet_relocked", 32'(o_aligned), 32'd0);
            if (i == 12) check("t5_relocked", 32'(o_aligned), 32'd1);
            if (i == 31) check("t5_rbd_gt_k_no_release", 32'(o_release), 32'd0);
        end

`ifdef RX_LMFC_STATS_EN
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        k = 5'd1;
        for (int it = 0; it < 257; it++) begin
            for (int c = 0; c < 8; c++) begin
                drive(1'b1, 1'(c == 0 || c == 2 || c == 4 || c == 5 || c == 7), 1'b0);
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_realign_saturated", 32'(o_realign_cnt), 32'd255);
`endif

        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
